// File: rtl/comm.sv
// UART command console: 8N1 receiver and transmitter plus a small FSM that reads
// or writes a 16-bit enable mask and replies with the mask MSB byte first.

module uart_rx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rx,
    output logic       ready,
    output logic [7:0] data,
    input  logic       rst
);
    localparam int CW = $clog2(CLK_PER_BIT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       state;
    logic            rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data    <= '0;
            ready   <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            ready   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state <= RX_START;
                        cnt   <= CW'(CLK_PER_BIT / 2 - 1);
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        // a start bit that is high again at its centre is a glitch
                        if (!rx_s2) begin
                            state   <= RX_DATA;
                            cnt     <= CW'(CLK_PER_BIT - 1);
                            bit_idx <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        cnt     <= CW'(CLK_PER_BIT - 1);
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        state <= RX_IDLE;
                        if (rx_s2) begin
                            data  <= shift;
                            ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

module uart_tx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic [7:0] data,
    input  logic       start,
    output logic       done,
    output logic       tx,
    input  logic       rst
);
    localparam int CW = $clog2(CLK_PER_BIT + 1);

    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    tx_state_t     state;
    logic [9:0]    frame;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            frame   <= '1;
            bit_idx <= '0;
            cnt     <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        frame   <= {1'b1, data, 1'b0};
                        tx      <= 1'b0;
                        bit_idx <= '0;
                        cnt     <= CW'(CLK_PER_BIT - 1);
                        state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (cnt == '0) begin
                        if (bit_idx == 4'd9) begin
                            state <= TX_IDLE;
                            done  <= 1'b1;
                            tx    <= 1'b1;
                        end else begin
                            frame   <= {1'b1, frame[9:1]};
                            tx      <= frame[1];
                            bit_idx <= bit_idx + 1'b1;
                            cnt     <= CW'(CLK_PER_BIT - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule

// state  | meaning
// IDLE   | waiting for a command byte
// WR_HI  | write command seen, waiting for mask high byte
// WR_LO  | waiting for mask low byte
// TX_HI  | sending reply high byte
// TX_LO  | sending reply low byte
module comm #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_rx,
    output logic        serial_tx,
    output logic [15:0] enabled_out
);
    localparam logic [7:0] COMM_READ_ENABLE_MASK  = 8'h01;
    localparam logic [7:0] COMM_WRITE_ENABLE_MASK = 8'h02;

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, TX_HI, TX_LO} comm_state_t;

    comm_state_t state;
    logic        rx_ready, tx_start, tx_done;
    logic [7:0]  rx_data, tx_data, wr_hi, snap_lo;

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk(clk), .rx(serial_rx), .ready(rx_ready), .data(rx_data), .rst(rst)
    );

    uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
        .clk(clk), .data(tx_data), .start(tx_start), .done(tx_done), .tx(serial_tx), .rst(rst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            enabled_out <= 16'h0000;
            wr_hi       <= '0;
            snap_lo     <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        if (rx_data == COMM_READ_ENABLE_MASK) begin
                            tx_data  <= enabled_out[15:8];
                            snap_lo  <= enabled_out[7:0];
                            tx_start <= 1'b1;
                            state    <= TX_HI;
                        end else if (rx_data == COMM_WRITE_ENABLE_MASK) begin
                            state <= WR_HI;
                        end
                    end
                end
                WR_HI: begin
                    if (rx_ready) begin
                        wr_hi <= rx_data;
                        state <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (rx_ready) begin
                        enabled_out <= {wr_hi, rx_data};
                        tx_data     <= wr_hi;
                        snap_lo     <= rx_data;
                        tx_start    <= 1'b1;
                        state       <= TX_HI;
                    end
                end
                TX_HI: begin
                    // received bytes are deliberately ignored while replying
                    if (tx_done) begin
                        tx_data  <= snap_lo;
                        tx_start <= 1'b1;
                        state    <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (tx_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_comm.sv
// Bench for comm: drives UART command frames, decodes serial_tx and compares
// replies and the mask against a command-level model of the console.

module tb_comm;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        serial_rx = 1'b1;
    logic        serial_tx;
    logic [15:0] enabled_out;

    logic [7:0]  solo_data = 8'h00;
    logic        solo_start = 1'b0;
    logic        solo_done, solo_tx;

    always #5 clk = ~clk;

    comm #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .serial_rx(serial_rx), .serial_tx(serial_tx), .enabled_out(enabled_out)
    );

    uart_tx #(.CLK_PER_BIT(CPB)) u_tx_solo (
        .clk(clk), .data(solo_data), .start(solo_start), .done(solo_done), .tx(solo_tx), .rst(rst)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // command-level model
    int          m_phase = 0;
    logic [15:0] m_mask  = 16'h0000;
    logic [7:0]  m_hi    = 8'h00;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    bit          dec_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good, input bit busy_at_start);
        if (!good || busy_at_start) return;
        case (m_phase)
            0: begin
                if (b == 8'h01) begin
                    exp_q.push_back(m_mask[15:8]);
                    exp_q.push_back(m_mask[7:0]);
                end else if (b == 8'h02) begin
                    m_phase = 1;
                end
            end
            1: begin
                m_hi    = b;
                m_phase = 2;
            end
            default: begin
                m_mask  = {m_hi, b};
                m_phase = 0;
                exp_q.push_back(m_hi);
                exp_q.push_back(b);
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit = 1'b1);
        bit busy;
        busy = (exp_q.size() != 0) || dec_busy;
        @(negedge clk);
        serial_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        serial_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        model_byte(b, stop_bit, busy);
    endtask

    task automatic wait_replies();
        int budget = 3000;
        while ((exp_q.size() != 0 || dec_busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reply_outstanding", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        chk("mask_vs_model", enabled_out, m_mask);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        m_phase = 0;
        m_mask  = 16'h0000;
        exp_q.delete();
    endtask

    // serial_tx decoder and reply compare
    initial begin
        logic [7:0] b;
        logic       start_low, stop_hi;
        logic [8:0] expv;
        forever begin
            @(negedge clk);
            if (!rst && serial_tx === 1'b0) begin
                dec_busy = 1'b1;
                repeat (CPB / 2 - 1) @(negedge clk);
                start_low = (serial_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = serial_tx;
                end
                repeat (CPB) @(negedge clk);
                stop_hi = (serial_tx === 1'b1);
                chk("reply_framing", {30'd0, start_low, stop_hi}, 32'd3);
                expv = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
                chk("reply_byte", {23'd0, 1'b0, b}, {23'd0, expv});
                got_q.push_back(b);
                dec_busy = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, lows, done_cyc, done_w;
        logic tx_after;

        repeat (5) @(negedge clk);
        chk("reset_serial_tx", serial_tx, 1'b1);
        chk("reset_mask", enabled_out, 16'h0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // read after reset
        base = got_q.size();
        send_byte(8'h01);
        wait_replies();
        chk("read0_count", got_q.size() - base, 2);
        chk("read0_b0", got_q[base], 8'h00);
        chk("read0_b1", got_q[base+1], 8'h00);
        chk("read0_vs_mask", {got_q[base], got_q[base+1]}, enabled_out);

        // write then read back
        base = got_q.size();
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'h3C);
        wait_replies();
        chk("write_mask", enabled_out, 16'hA53C);
        chk("write_echo_b0", got_q[base], 8'hA5);
        chk("write_echo_b1", got_q[base+1], 8'h3C);
        base = got_q.size();
        send_byte(8'h01);
        wait_replies();
        chk("read1_b0", got_q[base], 8'hA5);
        chk("read1_b1", got_q[base+1], 8'h3C);

        // unknown command: line stays quiet for 40 bit times
        send_byte(8'h7F);
        lows = 0;
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clk);
            if (serial_tx !== 1'b1) lows++;
        end
        chk("unknown_cmd_quiet", lows, 0);
        chk("unknown_cmd_mask", enabled_out, 16'hA53C);

        // second command arriving mid-reply is dropped
        base = got_q.size();
        send_byte(8'h01);
        send_byte(8'h01);
        wait_replies();
        repeat (12 * CPB) @(negedge clk);
        chk("drop_count", got_q.size() - base, 2);

        // reset aborts a partial write
        send_byte(8'h02);
        send_byte(8'h12);
        pulse_reset(1);
        chk("abort_mask", enabled_out, 16'h0000);
        base = got_q.size();
        send_byte(8'h01);
        wait_replies();
        chk("abort_b0", got_q[base], 8'h00);
        chk("abort_b1", got_q[base+1], 8'h00);

        // bad stop bit frame is ignored
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h81);
        wait_replies();
        base = got_q.size();
        send_byte(8'h01, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        send_byte(8'h01);
        wait_replies();
        chk("badstop_count", got_q.size() - base, 2);
        chk("badstop_reply", {got_q[base], got_q[base+1]}, 16'hC381);
        chk("badstop_mask", enabled_out, 16'hC381);

        // standalone transmitter timing
        @(negedge clk);
        solo_data  = 8'h55;
        solo_start = 1'b1;
        @(posedge clk);
        #1;
        solo_start = 1'b0;
        lows     = (solo_tx === 1'b0) ? 1 : 0;
        done_cyc = -1;
        done_w   = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (solo_done === 1'b1) begin
                done_w++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (solo_tx === 1'b0) lows++;
        end
        tx_after = solo_tx;
        chk("solo_done_cycle", done_cyc, 160);
        chk("solo_done_width", done_w, 1);
        chk("solo_low_cycles", lows, 80);
        chk("solo_idle_high", tx_after, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/comm.md
COMM -- requirements
Module: comm

Interface
REQ-001 Parameter CLK_PER_BIT, default 16, clock cycles per UART bit; SHALL be passed to both UART submodules.
REQ-002 Localparam COMM_READ_ENABLE_MASK, 8'h01, read-mask command byte; SHALL be hierarchically visible as comm.COMM_READ_ENABLE_MASK.
REQ-003 Localparam COMM_WRITE_ENABLE_MASK, 8'h02, write-mask command byte.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 serial_rx  input  1  UART receive line, idle high.
REQ-008 serial_tx  output  1  UART transmit line, idle high.
REQ-009 enabled_out  output  16  console enable mask; width is a multiple of 8 so it transfers as whole bytes.
REQ-010 Submodule uart_rx #(CLK_PER_BIT) ports in order: clk, rx, ready (1), data (8). Submodule uart_tx #(CLK_PER_BIT) ports in order: clk, data (8), start (1), done (1), tx (1). Both SHALL be usable standalone.

Function
REQ-011 UART format SHALL be 8N1, LSB first, each bit CLK_PER_BIT cycles, idle high.
REQ-012 uart_rx SHALL synchronize rx through 2 flops, detect a falling edge, re-check low at start-bit centre (CLK_PER_BIT/2), sample 8 data bits at bit centres, then sample the stop bit.
REQ-013 uart_rx SHALL pulse ready high for exactly 1 cycle on a valid stop bit (1), with data stable until the next frame completes; a start bit high at centre (glitch) or a stop bit 0 SHALL be discarded, no ready pulse.
REQ-014 uart_tx SHALL latch data when start is high on any cycle while idle, transmit start bit, 8 data bits, stop bit, then pulse done high 1 cycle at end of stop bit; start while busy SHALL be ignored; a 1-2 cycle start pulse SHALL suffice.
REQ-015 comm FSM states: IDLE, WR_HI, WR_LO, TX_HI, TX_LO.
REQ-016 IDLE + byte COMM_READ_ENABLE_MASK -> TX_HI; send enabled_out[15:8], on done -> TX_LO; send enabled_out[7:0], on done -> IDLE.
REQ-017 Reply bytes SHALL be the mask value snapshotted when the command byte is accepted (MSB byte first).
REQ-018 IDLE + byte COMM_WRITE_ENABLE_MASK -> WR_HI; next byte stored as new[15:8] -> WR_LO; next byte -> enabled_out <= {new_hi, byte} on the cycle after ready, then -> TX_HI (echo new mask as reply, same as read).
REQ-019 IDLE + any other byte SHALL be ignored: no reply, mask unchanged, stay IDLE.
REQ-020 Bytes received in TX_HI/TX_LO SHALL be dropped.
REQ-021 No inter-byte timeout: WR_HI/WR_LO wait indefinitely for data bytes.
REQ-022 enabled_out SHALL change only at REQ-018 completion or reset.

Reset
REQ-023 rst high SHALL force on the next edge: FSM IDLE, enabled_out 16'h0000, serial_tx 1, uart_rx/uart_tx idle, ready/done 0, pending write byte cleared.
REQ-024 Reset mid-frame or mid-command SHALL abort it; a partial write SHALL NOT modify enabled_out; a partially transmitted reply byte SHALL be cut, line returns high.

Verification
REQ-025 After reset, send 0x01 -> serial_tx emits 0x00 then 0x00; decoded 16'h0000 equals enabled_out.
REQ-026 Send 0x02,0xA5,0x3C -> enabled_out 16'hA53C; reply 0xA5,0x3C; then send 0x01 -> reply 0xA5,0x3C.
REQ-027 Send 0x7F -> no activity on serial_tx for 40 bit times; enabled_out unchanged.
REQ-028 Send 0x02,0x12 then assert rst 1 cycle, then 0x01 -> enabled_out stays 16'h0000; reply 0x00,0x00.
REQ-029 Send a frame with stop bit 0, then 0x01 -> bad frame ignored, exactly 2 reply bytes equal to enabled_out.
REQ-030 uart_tx standalone, CLK_PER_BIT=16, data 0x55, 1-cycle start -> frame 160 cycles, done pulse 1 cycle at cycle 160, line high after.
